// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//
// Purpose:
//   Bundles the hazard requests raised by the ID-stage detectors and the
//   pipeline-register controls returned by the stall controller.
//
// Signals:
//   branch_bubble    ID branch/JR/JALR operand not yet forwardable
//   load_use_bubble  lw in EX feeds the instruction in ID
//   id_redirect      ID resolved a taken branch or any jump this cycle
//   md_busy          multi-cycle mult/div unit busy, pipeline must freeze
//   pc_wr            PC write enable
//   ifid_wr          IF/ID write enable
//   ifid_flush       IF/ID load NOP
//   idex_wr          ID/EX write enable
//   idex_flush       ID/EX load NOP (bubble)
//
// Modports:
//   master  hazard detectors / pipeline side (drives requests)
//   slave   stall controller side (drives register controls)
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if;
    logic branch_bubble;
    logic load_use_bubble;
    logic id_redirect;
    logic md_busy;
    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_wr;
    logic idex_flush;

    modport master (
        output branch_bubble,
        output load_use_bubble,
        output id_redirect,
        output md_busy,
        input  pc_wr,
        input  ifid_wr,
        input  ifid_flush,
        input  idex_wr,
        input  idex_flush
    );

    modport slave (
        input  branch_bubble,
        input  load_use_bubble,
        input  id_redirect,
        input  md_busy,
        output pc_wr,
        output ifid_wr,
        output ifid_flush,
        output idex_wr,
        output idex_flush
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Turns ID-stage hazard requests into PC / IF/ID / ID/EX write enables and
//   flushes. Also tracks the hazard class of the previous cycle, runs a
//   stall-length watchdog and keeps saturating performance counters.
//
// Parameters:
//   DELAY_SLOT  1 = architectural delay slot (no IF/ID flush on redirect)
//   MAX_STALL   consecutive non-RUN cycles that trip the watchdog
//   CNT_W       width of each performance counter
//
// Ports:
//   clk            pipeline clock
//   rst_n          synchronous active-low reset
//   hz             request/control bundle (slave modport)
//   hazard_state   registered class of previous cycle: 0=RUN 1=STALL 2=MDWAIT
//   stall_timeout  sticky watchdog flag
//   stall_cnt      cycles spent inserting bubbles
//   flush_cnt      IF/ID flushes issued
//   md_cnt         cycles frozen on md_busy
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int DELAY_SLOT = 0,
    parameter int MAX_STALL  = 16,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_stall_ctrl_if.slave   hz,
    output logic [1:0]           hazard_state,
    output logic                 stall_timeout,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     md_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_MDWAIT = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    localparam int RL_W = $clog2(MAX_STALL + 1);
    localparam logic [RL_W-1:0]  RL_MAX  = RL_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic bubble;
    state_t cls;

    logic pc_wr_c;
    logic ifid_wr_c;
    logic ifid_flush_c;
    logic idex_wr_c;
    logic idex_flush_c;

    state_t           state_q, state_d;
    logic [RL_W-1:0]  run_len_q, run_len_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    assign bubble = hz.branch_bubble | hz.load_use_bubble;

    // md_busy outranks a bubble, which outranks a redirect.
    always_comb begin
        cls = ST_RUN;
        if (hz.md_busy) begin
            cls = ST_MDWAIT;
        end else if (bubble) begin
            cls = ST_STALL;
        end
    end

    // Pipeline register controls. A bubble ignores id_redirect because the
    // branch operands are not ready, so ID will present the redirect again.
    always_comb begin
        pc_wr_c      = 1'b1;
        ifid_wr_c    = 1'b1;
        idex_wr_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        if (!rst_n) begin
            pc_wr_c      = 1'b0;
            ifid_wr_c    = 1'b0;
            idex_wr_c    = 1'b0;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (hz.md_busy) begin
            pc_wr_c   = 1'b0;
            ifid_wr_c = 1'b0;
            idex_wr_c = 1'b0;
        end else if (bubble) begin
            pc_wr_c      = 1'b0;
            ifid_wr_c    = 1'b0;
            idex_flush_c = 1'b1;
        end else if (hz.id_redirect) begin
            ifid_flush_c = (DELAY_SLOT == 0);
        end
    end

    assign hz.pc_wr      = pc_wr_c;
    assign hz.ifid_wr    = ifid_wr_c;
    assign hz.idex_wr    = idex_wr_c;
    assign hz.ifid_flush = ifid_flush_c;
    assign hz.idex_flush = idex_flush_c;

    // Next state, watchdog and counters. The unused encoding always falls
    // back to RUN regardless of inputs.
    always_comb begin
        state_d     = cls;
        run_len_d   = run_len_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        md_cnt_d    = md_cnt_q;

        if (state_q == ST_UNUSED) begin
            state_d = ST_RUN;
        end

        if (cls == ST_RUN) begin
            run_len_d = '0;
        end else if (run_len_q != RL_MAX) begin
            run_len_d = run_len_q + RL_W'(1);
        end
        if (run_len_d == RL_MAX) begin
            timeout_d = 1'b1;
        end

        if (bubble && !hz.md_busy && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (hz.md_busy && md_cnt_q != CNT_MAX) begin
            md_cnt_d = md_cnt_q + CNT_W'(1);
        end
        if (ifid_flush_c && rst_n && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            run_len_q   <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            md_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

    assign hazard_state  = state_q;
    assign stall_timeout = timeout_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign md_cnt        = md_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Purpose:
//   Directed bench for hazard_stall_ctrl. Three instances share the same
//   stimulus: dut0 (DELAY_SLOT=0), dut1 (DELAY_SLOT=1) and dut2 (CNT_W=4)
//   so redirect flushing and counter saturation are seen side by side.
//   Inputs change just after the falling edge; everything is sampled 1ns
//   later, well clear of the rising edge.
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic clk;
    logic rst_n;

    int compare_count;
    int fail_count;

    hazard_stall_ctrl_if hz0 ();
    hazard_stall_ctrl_if hz1 ();
    hazard_stall_ctrl_if hz2 ();

    logic [1:0]  hs0, hs1, hs2;
    logic        to0, to1, to2;
    logic [31:0] sc0, fc0, mc0;
    logic [31:0] sc1, fc1, mc1;
    logic [3:0]  sc2, fc2, mc2;

    hazard_stall_ctrl #(.DELAY_SLOT(0), .MAX_STALL(16), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .hz(hz0),
        .hazard_state(hs0), .stall_timeout(to0),
        .stall_cnt(sc0), .flush_cnt(fc0), .md_cnt(mc0)
    );

    hazard_stall_ctrl #(.DELAY_SLOT(1), .MAX_STALL(16), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .hz(hz1),
        .hazard_state(hs1), .stall_timeout(to1),
        .stall_cnt(sc1), .flush_cnt(fc1), .md_cnt(mc1)
    );

    hazard_stall_ctrl #(.DELAY_SLOT(0), .MAX_STALL(16), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .hz(hz2),
        .hazard_state(hs2), .stall_timeout(to2),
        .stall_cnt(sc2), .flush_cnt(fc2), .md_cnt(mc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of requests into all three instances after the
    // falling edge, then waits 1ns so combinational outputs settle.
    task automatic applyStimulus(input logic rst, input logic bb, input logic lu,
                                 input logic rd, input logic md);
        @(negedge clk);
        rst_n = rst;
        hz0.branch_bubble = bb; hz0.load_use_bubble = lu;
        hz0.id_redirect = rd;   hz0.md_busy = md;
        hz1.branch_bubble = bb; hz1.load_use_bubble = lu;
        hz1.id_redirect = rd;   hz1.md_busy = md;
        hz2.branch_bubble = bb; hz2.load_use_bubble = lu;
        hz2.id_redirect = rd;   hz2.md_busy = md;
        #1;
    endtask

    // Compares dut0 controls packed as {pc_wr, ifid_wr, idex_wr, ifid_flush, idex_flush}.
    task automatic checkControls(input string tag, input logic [4:0] expected);
        checkOutput(tag, {27'd0, hz0.pc_wr, hz0.ifid_wr, hz0.idex_wr,
                          hz0.ifid_flush, hz0.idex_flush}, {27'd0, expected});
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        compare_count = 0;
        fail_count    = 0;

        // Reset held for two cycles; controls forced to the safe pattern.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkControls("reset_ctrl_c1", 5'b00011);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkControls("reset_ctrl_c2", 5'b00011);

        // Release with no requests.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkControls("idle_ctrl", 5'b11100);
        checkOutput("idle_state", hs0, 0);
        checkOutput("idle_stall_cnt", sc0, 0);
        checkOutput("idle_flush_cnt", fc0, 0);
        checkOutput("idle_md_cnt", mc0, 0);
        checkOutput("idle_timeout", to0, 0);

        // Single load-use bubble.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkControls("lu_ctrl", 5'b00101);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_state", hs0, 1);
        checkOutput("lu_stall_cnt", sc0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_state_back", hs0, 0);

        // Bubble together with redirect: bubble wins, no IF/ID flush.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkControls("bb_rd_ctrl", 5'b00101);

        // Redirect alone: flush only without a delay slot.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkControls("rd_ctrl_ds0", 5'b11110);
        checkOutput("rd_pc_wr_ds1", hz1.pc_wr, 1);
        checkOutput("rd_ifid_flush_ds1", hz1.ifid_flush, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rd_flush_cnt_ds0", fc0, 1);
        checkOutput("rd_flush_cnt_ds1", fc1, 0);
        checkOutput("rd_stall_cnt", sc0, 2);

        // Freeze with bubble and redirect all present for 3 cycles.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            checkControls($sformatf("prio_ctrl_%0d", i), 5'b00000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("prio_md_cnt", mc0, 3);
        checkOutput("prio_stall_cnt", sc0, 0);
        checkOutput("prio_flush_cnt", fc0, 0);
        checkOutput("prio_state", hs0, 2);

        // Reset in the middle of a freeze aborts it with clean counters.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkControls("mdrst_ctrl", 5'b00011);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mdrst_state", hs0, 0);
        checkOutput("mdrst_md_cnt", mc0, 0);

        // Watchdog: a RUN cycle restarts the run length, then 16 in a row trip it.
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_before_16", to0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_after_16", to0, 1);
        checkOutput("wd_state", hs0, 1);
        checkOutput("wd_stall_cnt", sc0, 26);
        checkOutput("sat_stall_cnt_w4", {28'd0, sc2}, 15);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_sticky", to0, 1);
        checkOutput("wd_state_run", hs0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_cleared", to0, 0);

        // Saturation: 20 consecutive bubbles on the 4-bit counter.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat20_stall_cnt_w4", {28'd0, sc2}, 15);
        checkOutput("sat20_stall_cnt_w32", sc0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Consumes the hazard requests raised in ID and turns them into pipeline register enables and flushes.
- Inputs: branch/JR/JALR operand bubble, load-use bubble, ID-resolved branch/jump redirect, multi-cycle mult/div busy.
- Outputs: pc_wr, IF/ID write/flush, ID/EX write/flush.
- Sits between the ID-stage hazard detectors and the PC / IF/ID / ID/EX registers.
- Keeps a small state machine, stall-length watchdog and saturating performance counters.

Parameters:
DELAY_SLOT, 0, 1 = architectural branch delay slot (no IF/ID flush on redirect); 0 = flush IF/ID on taken redirect
MAX_STALL, 16, consecutive non-RUN cycles that trip the watchdog
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous, active-low reset
branch_bubble  in  1  ID branch/JR/JALR operand not yet forwardable
load_use_bubble  in  1  lw in EX feeds instruction in ID
id_redirect  in  1  ID resolved a taken branch or any jump this cycle
md_busy  in  1  multi-cycle mult/div unit busy; pipeline must freeze
pc_wr  out  1  PC write enable
ifid_wr  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID load NOP
idex_wr  out  1  ID/EX write enable
idex_flush  out  1  ID/EX load NOP (bubble)
hazard_state  out  2  0=RUN, 1=STALL, 2=MDWAIT
stall_timeout  out  1  sticky watchdog flag
stall_cnt  out  CNT_W  cycles spent inserting bubbles
flush_cnt  out  CNT_W  IF/ID flushes issued
md_cnt  out  CNT_W  cycles frozen on md_busy

Behaviour:
Input classification:
- bubble = branch_bubble | load_use_bubble.
- Priority per cycle: md_busy > bubble > id_redirect.

Outputs are combinational from the current inputs, gated by rst_n:
- rst_n=0: pc_wr=0, ifid_wr=0, idex_wr=0, ifid_flush=1, idex_flush=1.
- md_busy=1 (freeze): pc_wr=0, ifid_wr=0, idex_wr=0, both flushes 0.
- bubble=1 with md_busy=0: pc_wr=0, ifid_wr=0, idex_wr=1, idex_flush=1, ifid_flush=0. id_redirect is ignored this cycle because the branch is not yet resolved.
- id_redirect=1 with no bubble and no md_busy: pc_wr=1, ifid_wr=1, idex_wr=1, idex_flush=0, ifid_flush = (DELAY_SLOT==0).
- Otherwise: all enables 1, all flushes 0.

State register (updated on the clk rising edge):
- Next state: MDWAIT if md_busy; else STALL if bubble; else RUN.
- rst_n=0 forces RUN.
- hazard_state shows the registered state, i.e. the previous cycle's classification.
- Encoding 3 is unused; if reached, return to RUN on the next edge.

Watchdog:
- run_len counts consecutive cycles whose classification is non-RUN. It is reset to 0 on any RUN-classified cycle.
- When run_len reaches MAX_STALL, set stall_timeout on that edge. It stays 1 until reset.
- run_len saturates at MAX_STALL.

Counters (all saturate at 2^CNT_W-1; no wrap):
- stall_cnt increments on each cycle with bubble=1 and md_busy=0.
- md_cnt increments on each md_busy cycle.
- flush_cnt increments on each cycle with ifid_flush=1 and rst_n=1.

Reset:
- All counters, run_len, stall_timeout and state clear synchronously when rst_n=0 at a clk edge.
- Reset mid-stall or mid-freeze aborts it; the next cycle is RUN with clean counters.

Simultaneous events:
- bubble and id_redirect together: bubble wins; redirect must be re-presented by ID next cycle.
- md_busy and bubble together: freeze only; idex_flush=0; stall_cnt does not increment.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release with no requests -> during reset pc_wr=0, ifid_flush=1, idex_flush=1; after release all enables 1, all counters 0, hazard_state=0.
- Load-use: load_use_bubble=1 for 1 cycle -> that cycle pc_wr=0, ifid_wr=0, idex_flush=1; next cycle hazard_state=1, stall_cnt=1; following cycle hazard_state=0.
- Redirect with DELAY_SLOT=0, then DELAY_SLOT=1: id_redirect=1 alone -> ifid_flush=1 and flush_cnt=1 for DELAY_SLOT=0; ifid_flush=0 and flush_cnt=0 for DELAY_SLOT=1. pc_wr=1 in both.
- Priority: md_busy=1, branch_bubble=1, id_redirect=1 together for 3 cycles -> all enables 0, no flushes, md_cnt=3, stall_cnt=0, hazard_state=2.
- Watchdog: branch_bubble=1 for 16 consecutive cycles with MAX_STALL=16 -> stall_timeout rises after the 16th edge and stays 1 after the bubble drops; rst_n=0 clears it.
- Saturation: with CNT_W=4, apply bubble for 20 cycles -> stall_cnt stops at 15.
